// File: rtl/fifo_sync_prog_if.sv
// Handshake/status bundle for fifo_sync_prog; the FIFO_PARITY_EN build adds the
// dout_perr/perr_sticky status lines.
interface fifo_sync_prog_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         level;
    logic [CW-1:0]         af_thresh;
    logic [CW-1:0]         ae_thresh;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  clr_err;
    logic                  overflow;
    logic                  underflow;
`ifdef FIFO_PARITY_EN
    logic                  dout_perr;
    logic                  perr_sticky;
`endif

    modport master (
        output flush, wr_en, din, rd_en, af_thresh, ae_thresh, clr_err,
        input  dout, rd_valid, full, empty, level, almost_full, almost_empty,
               overflow, underflow
`ifdef FIFO_PARITY_EN
        , input dout_perr, perr_sticky
`endif
    );

    modport slave (
        input  flush, wr_en, din, rd_en, af_thresh, ae_thresh, clr_err,
        output dout, rd_valid, full, empty, level, almost_full, almost_empty,
               overflow, underflow
`ifdef FIFO_PARITY_EN
        , output dout_perr, perr_sticky
`endif
    );
endinterface

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with standard/FWFT read, programmable almost flags, flush and
// sticky error flags. Define FIFO_PARITY_EN to store and check a per-word parity bit.
module fifo_sync_prog #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int FWFT       = 0
) (
    input logic             clk,
    input logic             rst,
    fifo_sync_prog_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
`ifdef FIFO_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_LVL = CW'(DEPTH);

    logic [MW-1:0]         mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  full;
    logic                  wr_fire;
    logic                  rd_take;        // memory word moves into the output register
    logic                  rd_pop;         // a word leaves the FIFO (level decrements)
    logic                  rd_miss;        // read request with nothing readable
    logic                  rd_valid_next;
    logic [MW-1:0]         wr_word;
    logic [MW-1:0]         rd_word;

    assign full    = (level_q == DEPTH_LVL);
    assign wr_fire = bus.wr_en && !full && !bus.flush;
    assign rd_word = mem[rd_ptr_q];

    if (FWFT != 0) begin : g_fwft
        // The output register holds one word, so memory holds level minus rd_valid.
        logic [CW-1:0] mem_count;
        always_comb begin
            mem_count     = level_q - CW'(rd_valid_q);
            rd_pop        = bus.rd_en && rd_valid_q && !bus.flush;
            rd_take       = (!rd_valid_q || rd_pop) && (mem_count != '0) && !bus.flush;
            rd_miss       = bus.rd_en && !rd_valid_q && !bus.flush;
            rd_valid_next = rd_take || (rd_valid_q && !rd_pop && !bus.flush);
        end
        assign bus.empty = !rd_valid_q;
    end else begin : g_std
        always_comb begin
            rd_pop        = bus.rd_en && (level_q != '0) && !bus.flush;
            rd_take       = rd_pop;
            rd_miss       = bus.rd_en && (level_q == '0) && !bus.flush;
            rd_valid_next = rd_pop;
        end
        assign bus.empty = (level_q == '0);
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        dout_d      = dout_q;
        rd_valid_d  = rd_valid_next;
        overflow_d  = (bus.wr_en && full && !bus.flush) || (overflow_q && !bus.clr_err);
        underflow_d = rd_miss || (underflow_q && !bus.clr_err);
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            end
            if (rd_take) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
                dout_d   = rd_word[DATA_WIDTH-1:0];
            end
            if (wr_fire && !rd_pop) begin
                level_d = level_q + CW'(1);
            end else if (!wr_fire && rd_pop) begin
                level_d = level_q - CW'(1);
            end
        end
    end

    // Storage is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            dout_q      <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            dout_q      <= dout_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef FIFO_PARITY_EN
    logic perr_q, perr_d;
    logic perr_sticky_q, perr_sticky_d;
    logic rd_bad;

    assign wr_word = {^bus.din, bus.din};
    assign rd_bad  = (^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH];

    always_comb begin
        perr_d        = rd_take ? rd_bad : perr_q;
        perr_sticky_d = (rd_take && rd_bad) || (perr_sticky_q && !bus.clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q        <= 1'b0;
            perr_sticky_q <= 1'b0;
        end else begin
            perr_q        <= perr_d;
            perr_sticky_q <= perr_sticky_d;
        end
    end

    assign bus.dout_perr   = perr_q;
    assign bus.perr_sticky = perr_sticky_q;
`else
    assign wr_word = bus.din;
`endif

    assign bus.dout         = dout_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full;
    assign bus.level        = level_q;
    assign bus.almost_full  = (level_q >= bus.af_thresh);
    assign bus.almost_empty = (level_q <= bus.ae_thresh);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/fifo_sync_prog.md
Name: fifo_sync_prog

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's 1-bit-control sync FIFO, and adds:
- selectable read mode: standard or first-word-fall-through (FWFT)
- programmable almost-full/almost-empty thresholds
- fill-level output, synchronous flush, sticky overflow/underflow error flags
Used between readout datapath stages and command/packet buffers wherever back-pressure needs early warning.

Parameters:
DATA_WIDTH, 16, payload width in bits (>=1)
DEPTH, 32, total word capacity (>=2; need not be a power of two)
FWFT, 0, 0 = standard read (data one cycle after rd_en), 1 = first-word-fall-through
CW, $clog2(DEPTH+1), width of level and threshold ports (derived; not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous clear of contents
wr_en  in  1  write request
din  in  DATA_WIDTH  write data
rd_en  in  1  read request (standard) / pop (FWFT)
dout  out  DATA_WIDTH  read data
rd_valid  out  1  standard: one-cycle pulse, dout updated; FWFT: dout holds head word
full  out  1  level == DEPTH
empty  out  1  standard: level == 0; FWFT: !rd_valid
level  out  CW  words held, including FWFT output-register word
af_thresh  in  CW  almost-full threshold
ae_thresh  in  CW  almost-empty threshold
almost_full  out  1  level >= af_thresh
almost_empty  out  1  level <= ae_thresh
clr_err  in  1  clears sticky error flags
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while nothing readable

Behaviour:
- Reset (async, rst=1): pointers=0, level=0, dout=0, rd_valid=0, overflow=0, underflow=0. Consequently full=0, empty=1, almost_full=(af_thresh==0), almost_empty=1. Memory is not reset.
- Write accepted iff wr_en && !full. A write while full is dropped, sets overflow, and leaves the memory unchanged, even when a read is accepted in the same cycle.
- Standard read:
  - accepted iff rd_en && level!=0
  - dout registered at the accepting edge; rd_valid=1 for exactly the following cycle
  - dout holds its value otherwise
  - rd_en while empty sets underflow, including when a write is accepted in the same cycle
- FWFT read:
  - head word is prefetched into the output register; rd_valid=1 while dout is valid
  - write into an empty FIFO at edge N gives rd_valid=1 after edge N+1
  - pop accepted iff rd_en && rd_valid; the next word is presented after the same edge if available (no bubble under continuous read)
  - rd_en with rd_valid=0 sets underflow
- Pointers wrap from DEPTH-1 to 0 explicitly.
- level: +1 on accepted write only, -1 on accepted read only, unchanged when both are accepted. It never exceeds DEPTH and never goes below 0.
- Flags (full, empty, almost_*) derive combinationally from the registered level/rd_valid and are valid the cycle after the causing edge. Thresholds compare unsigned and may change at any time.
- flush: at the edge where flush=1, pointers, level and rd_valid return to 0. It overrides any wr_en/rd_en in that cycle: nothing is written or read, and no error flag is set. dout and the error flags are retained.
- Error flags: set by the conditions above; cleared by clr_err; set wins over clear in the same cycle.
- rst asserted mid-transfer: immediate return to the reset state; in-flight data is lost.

Optional Feature:
FIFO_PARITY_EN
- Defined:
  - one even-parity bit per word is stored alongside din
  - additional output dout_perr (1 bit) is registered with dout and is 1 when the recomputed parity of the read word mismatches the stored parity
  - in standard mode it is qualified by rd_valid; in FWFT mode it is valid while rd_valid=1
  - reset value 0
  - a parity mismatch also sets a sticky perr_sticky output, cleared by clr_err
- Undefined: no extra storage bit, and the dout_perr/perr_sticky ports do not exist.

Test Plan:
- Standard mode (DEPTH=4): write 0xA1..0xA4 -> full=1, level=4; fifth write 0xA5 -> dropped, overflow=1. Read x4 -> dout A1,A2,A3,A4, each with a single-cycle rd_valid pulse; empty=1.
- FWFT mode: single write 0x55 at edge N -> rd_valid=1, dout=0x55 after edge N+1. Continuous wr+rd of 8 words -> output stream in order with no bubble.
- Simultaneous wr_en+rd_en at level=2 for 10 cycles -> level stays 2, data in order. Same at level=0 (standard) -> read rejected, underflow=1, level=1.
- Thresholds: af_thresh=3, ae_thresh=1; fill 0->4 -> almost_empty deasserts at level 2, almost_full asserts at level 3. Changing af_thresh to 5 -> almost_full=0 next cycle.
- Flush at level=3 with wr_en=1 -> level=0, empty=1, no write, error flags unchanged. clr_err with a simultaneous overflow condition -> overflow stays 1.
- rst pulse mid-burst (level=5) -> all outputs at reset values asynchronously; a subsequent write then read returns the new data only. With FIFO_PARITY_EN, forcing a stored bit flip -> dout_perr=1 and perr_sticky=1.
